mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge_pkg.sv | 27 ++
 rtl/mem_bus_bridge.sv | 100 ++++++++++
 tb/tb_mem_bus_bridge.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_bridge_pkg.sv
// Shared widths, FSM state type and request payload for the MEM-stage to
// external bus bridge.
package mem_bus_bridge_pkg;

    localparam int unsigned DATA_BUS    = 32;
    localparam int unsigned ADDR_BUS    = 32;
    localparam int unsigned MEM_SEL_BUS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Latched MEM request, replayed unchanged on the bus channel
    typedef struct packed {
        logic [MEM_SEL_BUS-1:0] we;
        logic [ADDR_BUS-1:0]    addr;
        logic [DATA_BUS-1:0]    wdata;
    } bus_req_t;

    function automatic logic is_read(input logic [MEM_SEL_BUS-1:0] we);
        return we == '0;
    endfunction

endpackage

// File: rtl/mem_bus_bridge.sv
// Bridges single MEM-stage loads/stores onto a split addr_ok/data_ok bus,
// stalling the pipeline and discarding responses of flushed accesses.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ram_en,
    input  logic [MEM_SEL_BUS-1:0] ram_write_en,
    input  logic [ADDR_BUS-1:0]    ram_addr,
    input  logic [DATA_BUS-1:0]    ram_write_data,
    input  logic                   flush,
    output logic [DATA_BUS-1:0]    ram_read_data,
    output logic                   stall_request,
    output logic                   bus_req,
    output logic [MEM_SEL_BUS-1:0] bus_we,
    output logic [ADDR_BUS-1:0]    bus_addr,
    output logic [DATA_BUS-1:0]    bus_wdata,
    input  logic                   bus_addr_ok,
    input  logic                   bus_data_ok,
    input  logic [DATA_BUS-1:0]    bus_rdata
);

    state_e                state_q, state_d;
    logic                  drop_q,  drop_d;
    bus_req_t              req_q,   req_d;
    logic [DATA_BUS-1:0]   rdata_q, rdata_d;
    logic                  drop_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    // A flush landing in the same cycle as the response also discards it
    assign drop_now = drop_q | flush;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (ram_en && !flush) begin
                    req_d   = '{we: ram_write_en, addr: ram_addr, wdata: ram_write_data};
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        if (!flush && is_read(req_q.we)) rdata_d = bus_rdata;
                        state_d = flush ? ST_IDLE : ST_DONE;
                    end else begin
                        // Accepted requests must be waited out even if flushed
                        drop_d  = flush;
                        state_d = ST_WAIT;
                    end
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    if (!drop_now && is_read(req_q.we)) rdata_d = bus_rdata;
                    drop_d  = 1'b0;
                    state_d = drop_now ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_req       = (state_q == ST_REQ);
    assign bus_we        = req_q.we;
    assign bus_addr      = req_q.addr;
    assign bus_wdata     = req_q.wdata;
    assign ram_read_data = rdata_q;
    assign stall_request = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                           ((state_q == ST_IDLE) && ram_en && !flush);

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Transaction-level bench for mem_bus_bridge: directed scenarios plus random
// loads/stores with random bus latencies and flush points.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        flush;
    logic [31:0] ram_read_data;
    logic        stall_request;
    logic        bus_req;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int          ncomp = 0;
    int          nfail = 0;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    mem_bus_bridge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .flush          (flush),
        .ram_read_data  (ram_read_data),
        .stall_request  (stall_request),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_addr_ok    (bus_addr_ok),
        .bus_data_ok    (bus_data_ok),
        .bus_rdata      (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access as seen from the pipeline. The bench plays the bus slave:
    // addr_ok after a cycles of bus_req, data_ok d cycles later (0 = same cycle).
    // ftype 1: flush on REQ cycle fidx (< a); ftype 2: flush on wait cycle fidx (< d).
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [3:0] we,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int a, input int d, input int ftype, input int fidx);
        int   reqcnt = 0;
        int   wc = 0;
        bit   addr_done = 0;
        bit   data_done = 0;
        bit   killed = 0;
        int   stall_cnt = 0;
        int   breq_cnt = 0;
        int   exp_stall;
        int   exp_breq;
        logic br;
        ram_addr       = addr;
        ram_write_en   = we;
        ram_write_data = wdata;
        for (int i = 0; i < a + d + 6; i++) begin
            @(negedge clk);
            br          = bus_req;
            ram_en      = (i == 0);
            flush       = 1'b0;
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            bus_rdata   = $urandom;
            if (br && !addr_done && !killed) begin
                check({tag, " bus_addr"},  bus_addr,       addr);
                check({tag, " bus_we"},    32'(bus_we),    32'(we));
                check({tag, " bus_wdata"}, bus_wdata,      wdata);
                if (ftype == 1 && reqcnt == fidx) begin
                    flush  = 1'b1;
                    killed = 1;
                end else if (reqcnt == a) begin
                    bus_addr_ok = 1'b1;
                    addr_done   = 1;
                    if (d == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = rdata;
                        data_done   = 1;
                    end
                end
                reqcnt++;
            end else if (addr_done && !data_done) begin
                wc++;
                if (ftype == 2 && wc == fidx + 1) flush = 1'b1;
                if (wc == d) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = rdata;
                    data_done   = 1;
                end
            end
            #1;
            stall_cnt += int'(stall_request);
            breq_cnt  += int'(br);
        end
        @(negedge clk);
        flush       = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (ftype == 1) begin
            exp_stall = fidx + 2;
            exp_breq  = fidx + 1;
        end else begin
            exp_stall = a + d + 2;
            exp_breq  = a + 1;
        end
        if (ftype == 0 && we == 4'b0000) exp_rd = rdata;
        check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, " bus_req_cycles"}, 32'(breq_cnt), 32'(exp_breq));
        check({tag, " ram_read_data"}, ram_read_data, exp_rd);
        check({tag, " idle_bus_req"}, 32'(bus_req), 32'd0);
    endtask

    initial begin
        int          req_idx[$];
        logic [31:0] rd2;
        int          a, d, ft, fi;
        logic [3:0]  we;

        rst_n = 1'b0; ram_en = 1'b0; ram_write_en = '0; ram_addr = '0;
        ram_write_data = '0; flush = 1'b0; bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0; bus_rdata = '0;
        exp_rd = '0;
        #2;
        check("reset bus_req",   32'(bus_req),       32'd0);
        check("reset stall",     32'(stall_request), 32'd0);
        check("reset rdata",     ram_read_data,      32'd0);
        check("reset bus_addr",  bus_addr,           32'd0);
        check("reset bus_we",    32'(bus_we),        32'd0);
        check("reset bus_wdata", bus_wdata,          32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn("min_read",  32'h0000_1004, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        run_txn("byte_store", 32'h0000_2008, 4'b0100, 32'h00AB_0000, 32'h1111_1111, 3, 0, 0, 0);
        run_txn("flush_wait", 32'h0000_300C, 4'b0000, 32'h0, 32'h1234_5678, 0, 2, 2, 1);
        run_txn("flush_req",  32'h0000_4000, 4'b0000, 32'h0, 32'h5555_AAAA, 3, 1, 1, 1);

        // flush in IDLE masks a pending access
        @(negedge clk);
        ram_en = 1'b1; flush = 1'b1;
        #1;
        check("idle_flush stall", 32'(stall_request), 32'd0);
        @(negedge clk);
        ram_en = 1'b0; flush = 1'b0;
        check("idle_flush bus_req", 32'(bus_req), 32'd0);

        // reset asserted while waiting for data; a late data_ok must be ignored
        @(negedge clk);
        ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h0000_5000;
        @(negedge clk);
        ram_en = 1'b0;
        check("rst_wait in_req", 32'(bus_req), 32'd1);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        check("rst_wait stall", 32'(stall_request), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wait bus_req",   32'(bus_req),       32'd0);
        check("rst_wait bus_addr",  bus_addr,           32'd0);
        check("rst_wait bus_we",    32'(bus_we),        32'd0);
        check("rst_wait bus_wdata", bus_wdata,          32'd0);
        check("rst_wait rdata",     ram_read_data,      32'd0);
        check("rst_wait stall0",    32'(stall_request), 32'd0);
        exp_rd = '0;
        @(negedge clk);
        rst_n = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        check("stray stall", 32'(stall_request), 32'd0);
        @(negedge clk);
        bus_data_ok = 1'b0;
        check("stray rdata",   ram_read_data, exp_rd);
        check("stray bus_req", 32'(bus_req),  32'd0);

        // back-to-back loads with ram_en held through the DONE cycle
        ram_write_en = 4'b0000; ram_addr = 32'h0000_6000; rd2 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ram_en      = (i < 4);
            bus_addr_ok = bus_req;
            bus_data_ok = bus_req;
            bus_rdata   = $urandom;
            if (bus_req) begin
                req_idx.push_back(i);
                rd2 = bus_rdata;
            end
            #1;
            if (i == 2) check("b2b done_stall", 32'(stall_request), 32'd0);
        end
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        exp_rd = rd2;
        check("b2b req_count", 32'(req_idx.size()), 32'd2);
        if (req_idx.size() == 2) begin
            check("b2b first_req",  32'(req_idx[0]), 32'd1);
            check("b2b second_req", 32'(req_idx[1]), 32'd4);
        end
        check("b2b rdata", ram_read_data, exp_rd);

        // random accesses
        for (int n = 0; n < 40; n++) begin
            a  = int'($urandom_range(0, 4));
            d  = int'($urandom_range(0, 4));
            ft = int'($urandom_range(0, 2));
            if (ft == 1 && a == 0) ft = 0;
            if (ft == 2 && d == 0) ft = 0;
            fi = 0;
            if (ft == 1) fi = int'($urandom_range(0, a - 1));
            if (ft == 2) fi = int'($urandom_range(0, d - 1));
            we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            run_txn($sformatf("rnd%0d", n), {$urandom} & 32'hFFFF_FFFC, we,
                    $urandom, $urandom, a, d, ft, fi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
